mem_stage_lsu: RTL and testbench

Parametrised memory-stage load/store unit sitting between the execute and writeback pipeline registers. It generates byte-lane-aligned stores with byte enables and extracts and extends loads at any naturally aligned offset. It talks to a data memory over a req/ready/rvalid handshake with variable latency, stalling the pipeline until the access completes, and flags misaligned or illegal accesses instead of issuing them. Non-memory instructions pass through with one cycle of latency and no stall.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_lane_align.sv | 95 +++++++++
 rtl/mem_stage_lsu.sv | 169 ++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit.
// Holds the funct3 encodings for loads and stores and the access FSM state type.
package lsu_pkg;

    // Load encodings (funct3)
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    // Store encodings (funct3)
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic for the load/store unit.
// Request side: byte enables, lane-replicated store data, misaligned/illegal decode.
// Response side: shifts the returned word down by the latched offset and extends it.
// Ports:
//   addr_lo     low address bits of the access being decoded
//   funct3      access size/signedness of the access being decoded
//   is_store    access being decoded is a store
//   store_data  raw store operand
//   be, wdata   byte enables and replicated store data
//   misaligned  address not a multiple of the access size
//   illegal     encoding not supported for this width/direction
//   rsp_off     latched byte offset of the outstanding load
//   rsp_funct3  latched funct3 of the outstanding load
//   rdata       raw memory response
//   load_data   extracted and extended load result
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int NB         = DATA_WIDTH / 8,
    localparam int OFFW       = $clog2(NB)
) (
    input  logic [2:0]            addr_lo,
    input  logic [2:0]            funct3,
    input  logic                  is_store,
    input  logic [DATA_WIDTH-1:0] store_data,
    output logic [NB-1:0]         be,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  misaligned,
    output logic                  illegal,
    input  logic [OFFW-1:0]       rsp_off,
    input  logic [2:0]            rsp_funct3,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] load_data
);

    logic [OFFW-1:0]       off;
    logic [DATA_WIDTH-1:0] shifted;

    assign off = addr_lo[OFFW-1:0];

    always_comb begin
        be    = '1;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                be    = NB'(1) << off;
                wdata = {NB{store_data[7:0]}};
            end
            2'b01: begin
                be    = NB'(2'b11) << off;
                wdata = {(NB/2){store_data[15:0]}};
            end
            2'b10: begin
                be    = NB'(4'hF) << off;
                wdata = {(NB/4){store_data[31:0]}};
            end
            default: begin
                be    = '1;
                wdata = store_data;
            end
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = |addr_lo[1:0];
            2'b11:   misaligned = |addr_lo[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Doubles and LWU only exist on the 64-bit datapath; stores have no unsigned forms.
    assign illegal = (funct3 == 3'b111)
                   | (is_store & funct3[2])
                   | ((DATA_WIDTH == 32) && ((funct3 == LD) || (funct3 == LWU)));

    assign shifted = rdata >> {rsp_off, 3'b000};

    // Size casts of signed operands sign-extend; LW on a 32-bit datapath reduces to a pass-through.
    always_comb begin
        case (rsp_funct3)
            LB:      load_data = DATA_WIDTH'($signed(shifted[7:0]));
            LH:      load_data = DATA_WIDTH'($signed(shifted[15:0]));
            LW:      load_data = DATA_WIDTH'($signed(shifted[31:0]));
            LBU:     load_data = DATA_WIDTH'(shifted[7:0]);
            LHU:     load_data = DATA_WIDTH'(shifted[15:0]);
            LWU:     load_data = DATA_WIDTH'(shifted[31:0]);
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit between the execute and writeback pipeline registers.
// Issues one aligned access at a time over a req/ready/rvalid handshake, stalling the
// pipeline until it completes; faulting accesses raise mem_exc instead of being issued.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid + *M inputs            instruction in the memory stage
//   stall                           hold upstream stages (M inputs must stay stable)
//   mem_req/we/addr/be/wdata        request to data memory, held until mem_ready
//   mem_ready, mem_rvalid, mem_rdata  memory handshake and load response
//   valid_W ... MemReadDataW        registered writeback outputs
//   mem_exc                         one-cycle pulse for misaligned/illegal accesses
//   RegWriteH, RdH, ALUResultH      forwarding taps of the M inputs
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 32,
    localparam int NB         = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] PCPlus4M,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] MemWriteDataM,
    input  logic [DATA_WIDTH-1:0] UpperImmExtM,
    input  logic                  RegWriteM,
    input  logic                  MemWriteM,
    input  logic                  MemReadM,
    input  logic [1:0]            ResultSrcM,
    input  logic [4:0]            RdM,
    input  logic [2:0]            Funct3M,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [NB-1:0]         mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  valid_W,
    output logic                  RegWriteW,
    output logic [1:0]            ResultSrcW,
    output logic [4:0]            RdW,
    output logic [DATA_WIDTH-1:0] PCPlus4W,
    output logic [DATA_WIDTH-1:0] ALUResultW,
    output logic [DATA_WIDTH-1:0] UpperImmExtW,
    output logic [DATA_WIDTH-1:0] MemReadDataW,
    output logic                  mem_exc,
    output logic                  RegWriteH,
    output logic [4:0]            RdH,
    output logic [DATA_WIDTH-1:0] ALUResultH
);

    localparam int OFFW = $clog2(NB);

    lsu_state_e            state, state_next;
    logic [ADDR_WIDTH-1:0] addr_m;
    logic                  mem_op, legal_op, fault;
    logic                  misaligned, illegal;
    logic [NB-1:0]         be_m;
    logic [DATA_WIDTH-1:0] wdata_m, load_data;
    logic [2:0]            lat_funct3;
    logic [OFFW-1:0]       lat_off;

    assign addr_m   = ADDR_WIDTH'(ALUResultM);
    assign mem_op   = in_valid & (MemReadM | MemWriteM);
    assign legal_op = mem_op & ~(misaligned | illegal);
    // Faults are only decoded for a fresh instruction; an accepted access was legal.
    assign fault    = mem_op & (misaligned | illegal) & (state == IDLE);

    assign RegWriteH  = RegWriteM;
    assign RdH        = RdM;
    assign ALUResultH = ALUResultM;

    lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .addr_lo    (addr_m[2:0]),
        .funct3     (Funct3M),
        .is_store   (MemWriteM),
        .store_data (MemWriteDataM),
        .be         (be_m),
        .wdata      (wdata_m),
        .misaligned (misaligned),
        .illegal    (illegal),
        .rsp_off    (lat_off),
        .rsp_funct3 (lat_funct3),
        .rdata      (mem_rdata),
        .load_data  (load_data)
    );

    assign mem_req = (state == REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (legal_op) begin
                    stall      = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                stall = !(mem_we & mem_ready);
                if (mem_ready) state_next = mem_we ? IDLE : RSP;
            end
            RSP: begin
                stall = !mem_rvalid;
                if (mem_rvalid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request fields are captured once and held for the whole handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            lat_funct3 <= '0;
            lat_off    <= '0;
        end else if ((state == IDLE) && legal_op) begin
            mem_we     <= MemWriteM;
            mem_addr   <= {addr_m[ADDR_WIDTH-1:OFFW], OFFW'(0)};
            mem_be     <= be_m;
            mem_wdata  <= wdata_m;
            lat_funct3 <= Funct3M;
            lat_off    <= addr_m[OFFW-1:0];
        end
    end

    // Writeback registers: a bubble while stalled, otherwise capture the M stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_W      <= 1'b0;
            RegWriteW    <= 1'b0;
            ResultSrcW   <= '0;
            RdW          <= '0;
            PCPlus4W     <= '0;
            ALUResultW   <= '0;
            UpperImmExtW <= '0;
            MemReadDataW <= '0;
            mem_exc      <= 1'b0;
        end else if (stall) begin
            valid_W   <= 1'b0;
            RegWriteW <= 1'b0;
            mem_exc   <= 1'b0;
        end else begin
            valid_W      <= in_valid;
            RegWriteW    <= in_valid & RegWriteM & ~fault;
            ResultSrcW   <= ResultSrcM;
            RdW          <= RdM;
            PCPlus4W     <= PCPlus4M;
            ALUResultW   <= ALUResultM;
            UpperImmExtW <= UpperImmExtM;
            MemReadDataW <= (state == RSP) ? load_data : '0;
            mem_exc      <= fault;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: a 32-bit and a 64-bit instance share stimulus; sel64 picks
// which one receives in_valid and whose outputs are observed.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, sel64;
    logic [63:0] pc, alu, wd, uimm, mem_rdata;
    logic        regwrite, memwrite, memread, mem_ready, mem_rvalid;
    logic [1:0]  rsrc;
    logic [4:0]  rd;
    logic [2:0]  f3;

    always #5 clk = ~clk;

    logic        s32, req32, we32, vw32, rw32, exc32, rwh32;
    logic [31:0] addr32, wdata32, pcw32, aluw32, uiw32, mrd32, aluh32;
    logic [3:0]  be32;
    logic [1:0]  rs32;
    logic [4:0]  rdw32, rdh32;

    logic        s64, req64, we64, vw64, rw64, exc64, rwh64;
    logic [31:0] addr64;
    logic [63:0] wdata64, pcw64, aluw64, uiw64, mrd64, aluh64;
    logic [7:0]  be64;
    logic [1:0]  rs64;
    logic [4:0]  rdw64, rdh64;

    mem_stage_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel64),
        .PCPlus4M(pc[31:0]), .ALUResultM(alu[31:0]), .MemWriteDataM(wd[31:0]),
        .UpperImmExtM(uimm[31:0]), .RegWriteM(regwrite), .MemWriteM(memwrite),
        .MemReadM(memread), .ResultSrcM(rsrc), .RdM(rd), .Funct3M(f3),
        .stall(s32), .mem_req(req32), .mem_we(we32), .mem_addr(addr32), .mem_be(be32),
        .mem_wdata(wdata32), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata[31:0]), .valid_W(vw32), .RegWriteW(rw32), .ResultSrcW(rs32),
        .RdW(rdw32), .PCPlus4W(pcw32), .ALUResultW(aluw32), .UpperImmExtW(uiw32),
        .MemReadDataW(mrd32), .mem_exc(exc32), .RegWriteH(rwh32), .RdH(rdh32),
        .ALUResultH(aluh32)
    );

    mem_stage_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel64),
        .PCPlus4M(pc), .ALUResultM(alu), .MemWriteDataM(wd),
        .UpperImmExtM(uimm), .RegWriteM(regwrite), .MemWriteM(memwrite),
        .MemReadM(memread), .ResultSrcM(rsrc), .RdM(rd), .Funct3M(f3),
        .stall(s64), .mem_req(req64), .mem_we(we64), .mem_addr(addr64), .mem_be(be64),
        .mem_wdata(wdata64), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .valid_W(vw64), .RegWriteW(rw64), .ResultSrcW(rs64),
        .RdW(rdw64), .PCPlus4W(pcw64), .ALUResultW(aluw64), .UpperImmExtW(uiw64),
        .MemReadDataW(mrd64), .mem_exc(exc64), .RegWriteH(rwh64), .RdH(rdh64),
        .ALUResultH(aluh64)
    );

    // Observed outputs of the selected instance, zero-extended to 64 bits.
    logic        o_stall, o_req, o_we, o_vw, o_rw, o_exc, o_rwh;
    logic [31:0] o_addr;
    logic [7:0]  o_be;
    logic [1:0]  o_rs;
    logic [4:0]  o_rd, o_rdh;
    logic [63:0] o_wdata, o_pc, o_alu, o_ui, o_mrd, o_aluh;

    assign o_stall = sel64 ? s64   : s32;
    assign o_req   = sel64 ? req64 : req32;
    assign o_we    = sel64 ? we64  : we32;
    assign o_vw    = sel64 ? vw64  : vw32;
    assign o_rw    = sel64 ? rw64  : rw32;
    assign o_exc   = sel64 ? exc64 : exc32;
    assign o_rwh   = sel64 ? rwh64 : rwh32;
    assign o_addr  = sel64 ? addr64 : addr32;
    assign o_be    = sel64 ? be64  : {4'b0, be32};
    assign o_rs    = sel64 ? rs64  : rs32;
    assign o_rd    = sel64 ? rdw64 : rdw32;
    assign o_rdh   = sel64 ? rdh64 : rdh32;
    assign o_wdata = sel64 ? wdata64 : {32'b0, wdata32};
    assign o_pc    = sel64 ? pcw64 : {32'b0, pcw32};
    assign o_alu   = sel64 ? aluw64 : {32'b0, aluw32};
    assign o_ui    = sel64 ? uiw64 : {32'b0, uiw32};
    assign o_mrd   = sel64 ? mrd64 : {32'b0, mrd32};
    assign o_aluh  = sel64 ? aluh64 : {32'b0, aluh32};

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: byte-level view of an access.
    function automatic logic [7:0] m_be(int nb, int size, int off);
        logic [7:0] r = '0;
        for (int i = 0; i < nb; i++) r[i] = (i >= off) && (i < off + size);
        return r;
    endfunction

    function automatic logic [63:0] m_wdata(int nb, int size, logic [63:0] d);
        logic [63:0] r = '0;
        for (int i = 0; i < nb; i++) r[i*8 +: 8] = d[(i % size)*8 +: 8];
        return r;
    endfunction

    function automatic logic [63:0] m_load(int nb, logic [2:0] fn, logic [63:0] rdat, int off);
        logic [63:0] r = '0;
        int size = 1 << fn[1:0];
        for (int i = 0; i < size; i++) r[i*8 +: 8] = rdat[(off + i)*8 +: 8];
        if (!fn[2] && r[size*8-1])
            for (int b = size*8; b < nb*8; b++) r[b] = 1'b1;
        return r;
    endfunction

    task automatic wait_neg();
        @(negedge clk);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_w(input logic exp_rw, input logic exp_exc, input logic [63:0] mask);
        chk("valid_W", o_vw, 1'b1);
        chk("RegWriteW", o_rw, exp_rw);
        chk("mem_exc", o_exc, exp_exc);
        chk("ResultSrcW", o_rs, rsrc);
        chk("RdW", o_rd, rd);
        chk("PCPlus4W", o_pc, pc & mask);
        chk("ALUResultW", o_alu, alu & mask);
        chk("UpperImmExtW", o_ui, uimm & mask);
    endtask

    // kind: 0 = non-memory, 1 = load, 2 = store. Called just after a rising edge.
    task automatic run_op(input bit s64i, input int kind, input logic [2:0] fn,
                          input logic [63:0] a, input logic [63:0] wdat, input logic [63:0] rdat,
                          input int rdly, input int vdly, input logic rwi, input logic [4:0] rdn);
        int nb = s64i ? 8 : 4;
        int size = 1 << fn[1:0];
        logic [63:0] mask = s64i ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        int off;
        bit mem, st, bad;
        off = int'(a[2:0]) % nb;
        mem = (kind != 0);
        st  = (kind == 2);
        bad = mem && ((size > nb) || (fn[2] && size >= nb) || (st && fn[2]) ||
                      ((int'(a[2:0]) % size) != 0));
        sel64 = s64i; in_valid = 1'b1; alu = a & mask; wd = wdat & mask;
        pc = {$urandom(), $urandom()} & mask; uimm = {$urandom(), $urandom()} & mask;
        regwrite = rwi; memwrite = st; memread = (kind == 1); f3 = fn;
        rsrc = 2'($urandom_range(0, 3)); rd = rdn; mem_ready = 1'b0; mem_rvalid = 1'b0;
        wait_neg();
        chk("stall_idle", o_stall, mem && !bad);
        chk("req_idle", o_req, 1'b0);
        chk("RegWriteH", o_rwh, rwi);
        chk("RdH", o_rdh, rdn);
        chk("ALUResultH", o_aluh, a & mask);
        if (!mem || bad) begin
            next_cyc();
            in_valid = 1'b0;
            chk_w(rwi && !bad, bad, mask);
            if (bad) begin
                wait_neg();
                chk("no_req_fault", o_req, 1'b0);
                next_cyc();
                chk("exc_pulse_end", o_exc, 1'b0);
            end
            return;
        end
        next_cyc();
        for (int c = 0; c <= rdly; c++) begin
            mem_ready = (c == rdly);
            wait_neg();
            chk("mem_req", o_req, 1'b1);
            chk("mem_we", o_we, st);
            chk("mem_addr", o_addr, a[31:0] & ~(32'(nb) - 32'd1));
            chk("mem_be", o_be, m_be(nb, size, off));
            if (st) chk("mem_wdata", o_wdata, m_wdata(nb, size, wdat));
            chk("stall_req", o_stall, !(st && mem_ready));
            chk("bubble_req", o_vw, 1'b0);
            next_cyc();
        end
        mem_ready = 1'b0;
        if (st) begin
            in_valid = 1'b0;
            chk_w(rwi, 1'b0, mask);
            return;
        end
        for (int c = 0; c <= vdly; c++) begin
            mem_rvalid = (c == vdly);
            mem_rdata  = (c == vdly) ? (rdat & mask) : {$urandom(), $urandom()};
            wait_neg();
            chk("stall_rsp", o_stall, c != vdly);
            chk("req_rsp", o_req, 1'b0);
            chk("bubble_rsp", o_vw, 1'b0);
            next_cyc();
        end
        mem_rvalid = 1'b0;
        in_valid = 1'b0;
        chk_w(rwi, 1'b0, mask);
        chk("MemReadDataW", o_mrd, m_load(nb, fn, rdat & mask, off));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; sel64 = 1'b0;
        pc = '0; alu = '0; wd = '0; uimm = '0; mem_rdata = '0;
        regwrite = 1'b0; memwrite = 1'b0; memread = 1'b0; rsrc = '0; rd = '0; f3 = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        #2;
        chk("rst_req", o_req, 1'b0);
        chk("rst_valid_W", o_vw, 1'b0);
        chk("rst_exc", o_exc, 1'b0);
        chk("rst_addr", o_addr, '0);
        chk("rst_be", o_be, '0);
        chk("rst_wdata", o_wdata, '0);
        chk("rst_we", o_we, 1'b0);
        chk("rst_mrd", o_mrd, '0);
        next_cyc();
        rst_n = 1'b1;
        next_cyc();

        // SB at 0x1003, ready on first REQ
        run_op(1'b0, 2, 3'b000, 64'h1003, 64'hA5, '0, 0, 0, 1'b0, 5'd0);
        // LB / LBU at 0x1002, rvalid three cycles after ready
        run_op(1'b0, 1, 3'b000, 64'h1002, '0, 64'h0080_0000, 0, 3, 1'b1, 5'd7);
        chk("LB_value", o_mrd, 64'hFFFF_FF80);
        run_op(1'b0, 1, 3'b100, 64'h1002, '0, 64'h0080_0000, 0, 3, 1'b1, 5'd7);
        chk("LBU_value", o_mrd, 64'h0000_0080);
        // Misaligned LH
        run_op(1'b0, 1, 3'b001, 64'h1001, '0, '0, 0, 0, 1'b1, 5'd3);
        // Non-memory op
        run_op(1'b0, 0, 3'b000, 64'h1234, '0, '0, 0, 0, 1'b1, 5'd5);
        // SW with ready held low for four cycles
        run_op(1'b0, 2, 3'b010, 64'h2008, 64'hDEAD_BEEF, '0, 4, 0, 1'b0, 5'd0);

        // Reset while waiting for a load response; a late rvalid is ignored
        sel64 = 1'b0; in_valid = 1'b1; alu = 64'h3000; memread = 1'b1; memwrite = 1'b0;
        regwrite = 1'b1; f3 = 3'b010; mem_ready = 1'b1;
        next_cyc();
        next_cyc();
        mem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        in_valid = 1'b0;
        wait_neg();
        chk("rstmid_req", o_req, 1'b0);
        chk("rstmid_stall", o_stall, 1'b0);
        chk("rstmid_addr", o_addr, '0);
        chk("rstmid_be", o_be, '0);
        next_cyc();
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 64'h1111_2222;
        wait_neg();
        chk("late_rvalid_stall", o_stall, 1'b0);
        next_cyc();
        mem_rvalid = 1'b0;
        chk("late_rvalid_vw", o_vw, 1'b0);
        chk("late_rvalid_mrd", o_mrd, '0);
        memread = 1'b0;

        // 64-bit datapath
        run_op(1'b1, 1, 3'b110, 64'h1004, '0, 64'hFFFF_FFFF_0000_0000, 1, 0, 1'b1, 5'd9);
        chk("LWU64_value", o_mrd, 64'h0000_0000_FFFF_FFFF);
        run_op(1'b1, 2, 3'b011, 64'h1000, 64'h0123_4567_89AB_CDEF, '0, 0, 0, 1'b0, 5'd0);
        run_op(1'b1, 1, 3'b011, 64'h1008, '0, 64'h8765_4321_0FED_CBA9, 0, 1, 1'b1, 5'd4);

        // Randomized operations
        for (int n = 0; n < 80; n++) begin
            logic [2:0]  fn = 3'($urandom_range(0, 7));
            logic [63:0] a  = {$urandom(), 16'h0, 16'($urandom())};
            if ($urandom_range(0, 3) != 0) a = a & ~(64'((1 << fn[1:0]) - 1));
            run_op(1'($urandom_range(0, 1)), $urandom_range(0, 2), fn, a,
                   {$urandom(), $urandom()}, {$urandom(), $urandom()},
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end

        next_cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
